rrq_wrr: RTL and testbench

Parametrised weighted round-robin read-request arbiter; successor to the fixed-rule read request queue. It selects one of `TOTAL_APPS` application data queues and issues a held read request tagged with `app_id` toward the shared read path. It adds per-app enable, per-app burst weight and occupancy back-pressure, and stalls when downstream FIFO room is short. It sits between the per-app data queues and the shared output FIFO/read engine.

---
 rtl/rrq_pkg.sv | 23 ++
 rtl/rr_pick.sv | 45 ++++
 rtl/rrq_wrr.sv | 148 ++++++++++++++
 tb/tb_rrq_wrr.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rrq_pkg.sv
// rrq_pkg: shared types and helpers for the weighted round-robin read-request
// arbiter.
//   rrq_state_t : request FSM states (IDLE, BUSY)
//   weight_eff  : maps a burst weight of zero to one; wider callers must
//                 not exceed WEIGHT_MAX_WIDTH bits.
package rrq_pkg;

    localparam int WEIGHT_MAX_WIDTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } rrq_state_t;

    // A zero weight would otherwise starve the burst counter comparison,
    // so it behaves as a single-request burst.
    function automatic logic [WEIGHT_MAX_WIDTH-1:0] weight_eff(
        input logic [WEIGHT_MAX_WIDTH-1:0] w
    );
        return (w == '0) ? WEIGHT_MAX_WIDTH'(1) : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating priority encoder.
// Returns the first asserted request found scanning upward from ptr, wrapping
// from N_REQ-1 back to 0.
//   req   : request vector, bit i = requester i
//   ptr   : starting position of the scan (must be < N_REQ)
//   valid : at least one request asserted
//   idx   : winning requester index (0 when valid is low)
module rr_pick #(
    parameter int N_REQ     = 8,
    parameter int IDX_WIDTH = 3
) (
    input  logic [N_REQ-1:0]     req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic                 valid,
    output logic [IDX_WIDTH-1:0] idx
);

    localparam int SW = IDX_WIDTH + 1;

    logic [SW-1:0]        sum_w [N_REQ];
    logic [IDX_WIDTH-1:0] cand  [N_REQ];
    logic [N_REQ-1:0]     hit;

    // cand[gi] is the requester visited at scan offset gi.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        assign sum_w[gi] = {1'b0, ptr} + SW'(gi);
        assign cand[gi]  = (sum_w[gi] >= SW'(N_REQ))
                         ? IDX_WIDTH'(sum_w[gi] - SW'(N_REQ))
                         : sum_w[gi][IDX_WIDTH-1:0];
        assign hit[gi]   = req[cand[gi]];
    end

    // Scan from the far end down so the smallest offset wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                valid = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/rrq_wrr.sv
// rrq_wrr: weighted round-robin read-request arbiter.
// Picks one of TOTAL_APPS application queues and holds a read request tagged
// with app_id until the read path reports read_done. Each app may keep the
// grant for up to its weight in consecutive requests before the pointer moves
// on. Issue is blocked while the downstream FIFO is above occ_limit.
//   clk, rst          : clock, asynchronous active-high reset
//   data_queue_empty  : bit i high = app i has nothing to read
//   app_enable        : bit i low = app i excluded
//   weight            : per-app burst weight, 0 behaves as 1
//   occupants         : downstream FIFO occupancy
//   occ_limit         : issue only when occupants <= occ_limit
//   read_done         : current request finished
//   read_queue        : read request, held until read_done
//   app_id            : granted app, stable while read_queue is high
//   room_stall        : an app is waiting but occupancy blocks issue
module rrq_wrr
    import rrq_pkg::*;
#(
    parameter int TOTAL_APPS     = 8,
    parameter int APP_ID_WIDTH   = 3,
    parameter int FIFO_ADD_WIDTH = 10,
    parameter int WEIGHT_WIDTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [TOTAL_APPS-1:0]              data_queue_empty,
    input  logic [TOTAL_APPS-1:0]              app_enable,
    input  logic [TOTAL_APPS*WEIGHT_WIDTH-1:0] weight,
    input  logic [FIFO_ADD_WIDTH-1:0]          occupants,
    input  logic [FIFO_ADD_WIDTH-1:0]          occ_limit,
    input  logic                               read_done,
    output logic                               read_queue,
    output logic [APP_ID_WIDTH-1:0]            app_id,
    output logic                               room_stall
);

    rrq_state_t              state_q, state_d;
    logic                    read_queue_q, read_queue_d;
    logic [APP_ID_WIDTH-1:0] app_id_q, app_id_d;
    logic                    room_stall_q, room_stall_d;
    logic [APP_ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [APP_ID_WIDTH-1:0] cur_app_q, cur_app_d;
    logic [WEIGHT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
    logic [WEIGHT_WIDTH-1:0] w_eff_q, w_eff_d;

    logic [TOTAL_APPS-1:0]   eligible;
    logic [WEIGHT_WIDTH-1:0] weight_arr [TOTAL_APPS];
    logic                    pick_valid;
    logic [APP_ID_WIDTH-1:0] pick_idx;
    logic                    room_ok;
    logic [WEIGHT_WIDTH:0]   burst_inc;
    logic                    burst_end;
    logic [APP_ID_WIDTH-1:0] next_ptr;

    assign eligible = ~data_queue_empty & app_enable;
    assign room_ok  = (occupants <= occ_limit);

    for (genvar gi = 0; gi < TOTAL_APPS; gi++) begin : g_weight
        assign weight_arr[gi] = weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    rr_pick #(
        .N_REQ     (TOTAL_APPS),
        .IDX_WIDTH (APP_ID_WIDTH)
    ) u_pick (
        .req   (eligible),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // One extra bit so burst_cnt+1 cannot wrap before the weight compare.
    assign burst_inc = {1'b0, burst_cnt_q} + 1'b1;
    // The burst also ends early if the granted app drained or was disabled.
    assign burst_end = (burst_inc >= {1'b0, w_eff_q}) || !eligible[cur_app_q];
    assign next_ptr  = (cur_app_q == APP_ID_WIDTH'(TOTAL_APPS - 1))
                     ? '0 : cur_app_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        read_queue_d = read_queue_q;
        app_id_d     = app_id_q;
        ptr_d        = ptr_q;
        cur_app_d    = cur_app_q;
        burst_cnt_d  = burst_cnt_q;
        w_eff_d      = w_eff_q;
        room_stall_d = (state_q == IDLE) && (|eligible) && !room_ok;

        case (state_q)
            IDLE: begin
                if (pick_valid && room_ok) begin
                    state_d      = BUSY;
                    read_queue_d = 1'b1;
                    app_id_d     = pick_idx;
                    // Weight is latched here so later changes only affect
                    // the next grant evaluation.
                    w_eff_d      = WEIGHT_WIDTH'(weight_eff(
                                       WEIGHT_MAX_WIDTH'(weight_arr[pick_idx])));
                    if (pick_idx != cur_app_q) begin
                        cur_app_d   = pick_idx;
                        burst_cnt_d = '0;
                    end
                end
            end
            BUSY: begin
                if (read_done) begin
                    state_d      = IDLE;
                    read_queue_d = 1'b0;
                    if (burst_end) begin
                        ptr_d       = next_ptr;
                        burst_cnt_d = '0;
                    end else begin
                        ptr_d       = cur_app_q;
                        burst_cnt_d = burst_inc[WEIGHT_WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            read_queue_q <= 1'b0;
            app_id_q     <= '0;
            room_stall_q <= 1'b0;
            ptr_q        <= '0;
            cur_app_q    <= '0;
            burst_cnt_q  <= '0;
            w_eff_q      <= WEIGHT_WIDTH'(1);
        end else begin
            state_q      <= state_d;
            read_queue_q <= read_queue_d;
            app_id_q     <= app_id_d;
            room_stall_q <= room_stall_d;
            ptr_q        <= ptr_d;
            cur_app_q    <= cur_app_d;
            burst_cnt_q  <= burst_cnt_d;
            w_eff_q      <= w_eff_d;
        end
    end

    assign read_queue = read_queue_q;
    assign app_id     = app_id_q;
    assign room_stall = room_stall_q;

endmodule

// File: tb/tb_rrq_wrr.sv
module tb_rrq_wrr;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int FW = 10;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    dqe;
    logic [N-1:0]    en;
    logic [N*WW-1:0] weight;
    logic [FW-1:0]   occ;
    logic [FW-1:0]   lim;
    logic            done;
    logic            rq;
    logic [AW-1:0]   app_id;
    logic            stall;

    always #5 clk = ~clk;

    rrq_wrr #(
        .TOTAL_APPS     (N),
        .APP_ID_WIDTH   (AW),
        .FIFO_ADD_WIDTH (FW),
        .WEIGHT_WIDTH   (WW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .data_queue_empty (dqe),
        .app_enable       (en),
        .weight           (weight),
        .occupants        (occ),
        .occ_limit        (lim),
        .read_done        (done),
        .read_queue       (rq),
        .app_id           (app_id),
        .room_stall       (stall)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: request state in plain integers.
    bit m_busy;
    bit m_stall;
    int m_app, m_ptr, m_cur, m_cnt, m_w, m_age;

    task automatic model_reset();
        m_busy = 0; m_stall = 0;
        m_app = 0; m_ptr = 0; m_cur = 0; m_cnt = 0; m_w = 1; m_age = 0;
    endtask

    task automatic model_update();
        bit [N-1:0] elig;
        bit         ok;
        int         p;
        int         w;
        elig = ~dqe & en;
        ok   = (int'(occ) <= int'(lim));
        m_stall = !m_busy && (elig != 0) && !ok;
        if (!m_busy) begin
            if (elig != 0 && ok) begin
                p = -1;
                for (int k = 0; k < N; k++)
                    if (p < 0 && elig[(m_ptr + k) % N]) p = (m_ptr + k) % N;
                w = int'(weight[p*WW +: WW]);
                m_busy = 1;
                m_app  = p;
                m_w    = (w == 0) ? 1 : w;
                m_age  = 0;
                if (p != m_cur) begin
                    m_cur = p;
                    m_cnt = 0;
                end
            end
        end else if (done) begin
            m_busy = 0;
            if (m_cnt + 1 >= m_w || !elig[m_cur]) begin
                m_ptr = (m_cur + 1) % N;
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
                m_ptr = m_cur;
            end
        end else begin
            m_age++;
        end
    endtask

    // Observed grant history.
    int got_seq[$];
    int gaps[$];
    int exp_q[$];
    bit prev_rq;
    bit seen_grant;
    int low_run;

    task automatic clear_hist();
        got_seq.delete();
        gaps.delete();
        prev_rq = 0; seen_grant = 0; low_run = 0;
    endtask

    // One clock: inputs already driven; model advances at the edge, outputs
    // compared at the following falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_update();
        @(negedge clk);
        check_val("read_queue", rq, 32'(m_busy));
        check_val("app_id", app_id, m_app);
        check_val("room_stall", stall, 32'(m_stall));
        if (rq && !prev_rq) begin
            if (seen_grant) gaps.push_back(low_run);
            got_seq.push_back(int'(app_id));
            seen_grant = 1;
            $display("grant app=%0d t=%0t", app_id, $time);
        end
        low_run = rq ? 0 : low_run + 1;
        prev_rq = rq;
    endtask

    // read_done is sampled at the edge 'delay' cycles after the grant edge.
    task automatic run_until(input int n, input int delay);
        int cyc = 0;
        while (got_seq.size() < n && cyc < 300) begin
            done = m_busy && (m_age + 1 >= delay);
            step();
            cyc++;
        end
        done = 0;
        check_val("grant_timeout", 32'(got_seq.size() >= n), 1);
    endtask

    task automatic check_seq(input string tag);
        for (int i = 0; i < exp_q.size(); i++)
            check_val(tag, (i < got_seq.size()) ? got_seq[i] : -1, exp_q[i]);
    endtask

    task automatic do_reset();
        rst = 1; done = 0;
        step();
        step();
        rst = 0;
        clear_hist();
    endtask

    initial begin
        rst = 1; done = 0;
        dqe = '0; en = '1; occ = '0; lim = 10'd100;
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        model_reset();
        clear_hist();
        #1;
        check_val("rst_read_queue", rq, 0);
        check_val("rst_app_id", app_id, 0);
        check_val("rst_room_stall", stall, 0);
        @(negedge clk);

        // Basic round robin with read_done two cycles after each grant.
        do_reset();
        run_until(5, 2);
        exp_q = '{0, 1, 2, 3, 0};
        check_seq("rr_seq");
        for (int i = 0; i < gaps.size(); i++) check_val("rr_gap", gaps[i], 1);

        // Weighted bursts, weight 0 acting as 1.
        do_reset();
        weight = {4'd2, 4'd0, 4'd1, 4'd3};
        run_until(10, 2);
        exp_q = '{0, 0, 0, 1, 2, 3, 3, 0, 0, 0};
        check_seq("wrr_seq");

        // Empty / disabled apps skipped; read_done while idle ignored.
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        dqe = 4'b0010; en = 4'b1011;
        run_until(4, 2);
        exp_q = '{0, 3, 0, 3};
        check_seq("skip_seq");
        run_until(5, 2);
        dqe = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            done = m_busy || (i > 1);
            step();
        end
        done = 0;
        check_val("idle_done_rq", rq, 0);
        dqe = 4'b0010;
        clear_hist();
        run_until(2, 2);
        exp_q = '{3, 0};
        check_seq("idle_done_seq");

        // Occupancy back-pressure.
        do_reset();
        dqe = '0; en = '1;
        occ = 10'd101; lim = 10'd100;
        for (int i = 0; i < 3; i++) step();
        check_val("bp_rq", rq, 0);
        check_val("bp_stall", stall, 1);
        occ = 10'd100;
        step();
        check_val("bp_grant", rq, 1);
        check_val("bp_stall_clr", stall, 0);
        occ = 10'd0;

        // App 0 drains during its second request of a weight-4 burst.
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd4};
        run_until(2, 2);
        dqe = 4'b0001;
        run_until(3, 2);
        dqe = 4'b0000;
        run_until(10, 2);
        exp_q = '{0, 0, 1, 2, 3, 0, 0, 0, 0, 1};
        check_seq("drain_seq");

        // Asynchronous reset while a request is outstanding.
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        run_until(2, 2);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check_val("arst_rq", rq, 0);
        check_val("arst_app_id", app_id, 0);
        check_val("arst_stall", stall, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        clear_hist();
        run_until(1, 2);
        exp_q = '{0};
        check_seq("arst_first");

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) dqe = N'($urandom);
            if ($urandom_range(0, 15) == 0) en = N'($urandom) | N'($urandom);
            if ($urandom_range(0, 31) == 0)
                for (int a = 0; a < N; a++) weight[a*WW +: WW] = WW'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) occ = FW'($urandom_range(0, 20));
            if ($urandom_range(0, 15) == 0) lim = FW'($urandom_range(0, 25));
            done = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
